// File: rtl/ntt_io_ctrl_if.sv
// Bundled ports between the NTT I/O controller and its surroundings:
// input stream, bank write port, core launch/finish, bank read port,
// output stream and job status.
interface ntt_io_ctrl_if #(
  parameter int D_width = 17,
  parameter int BN      = 16,
  parameter int MA      = 64
);
  localparam int AW = (MA > 1) ? $clog2(MA) : 1;
  localparam int BW = (BN > 1) ? $clog2(BN) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [D_width-1:0] in_data;
  logic [BN-1:0]      wr_en;
  logic [AW-1:0]      wr_addr;
  logic [D_width-1:0] wr_data;
  logic               start;
  logic               ntt_done;
  logic               rd_en;
  logic [BW-1:0]      rd_bank;
  logic [AW-1:0]      rd_addr;
  logic [D_width-1:0] rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [D_width-1:0] out_data;
  logic               busy;
  logic               done;

  // Controller side
  modport master (
    input  in_valid, in_data, ntt_done, rd_data, out_ready,
    output in_ready, wr_en, wr_addr, wr_data, start, rd_en, rd_bank,
           rd_addr, out_valid, out_data, busy, done
  );

  // Environment side (producer, banks, NTT core, consumer)
  modport slave (
    output in_valid, in_data, ntt_done, rd_data, out_ready,
    input  in_ready, wr_en, wr_addr, wr_data, start, rd_en, rd_bank,
           rd_addr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/ntt_io_ctrl.sv
// NTT I/O controller: scatters an input coefficient stream across BN banks,
// launches the NTT core, waits for it, then streams the coefficients back
// out in index order with a single outstanding bank read.
// Coefficient i lives in bank i%BN at address i/BN; BN and MA are expected
// to be powers of two (>= 2) so that split is a plain bit slice of i.
module ntt_io_ctrl #(
  parameter int D_width = 17,
  parameter int BN      = 16,
  parameter int MA      = 64
) (
  input  logic          clk,
  input  logic          rst,
  ntt_io_ctrl_if.master bus
);
  localparam int AW  = (MA > 1) ? $clog2(MA) : 1;
  localparam int BW  = (BN > 1) ? $clog2(BN) : 1;
  localparam int DEG = BN * MA;
  localparam int IW  = $clog2(DEG);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEG - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_UNLOAD = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ld_idx_q, ld_idx_d;    // next input beat index
  logic [IW-1:0]      rd_idx_q, rd_idx_d;    // next bank read index
  logic [IW-1:0]      out_idx_q, out_idx_d;  // next output beat index
  logic               rd_all_q, rd_all_d;    // every index already read
  logic               inflight_q, inflight_d;
  logic               out_valid_q, out_valid_d;
  logic [D_width-1:0] out_data_q, out_data_d;

  logic in_acc_s;
  logic rd_issue_s;
  logic out_acc_s;

  assign in_acc_s   = bus.in_valid && (state_q == S_LOAD);
  assign out_acc_s  = out_valid_q && bus.out_ready;
  // A read may start only when the output register is free or being drained
  // this cycle, so returning data never overwrites an unaccepted beat.
  assign rd_issue_s = (state_q == S_UNLOAD) && !rd_all_q && !inflight_q &&
                      (!out_valid_q || bus.out_ready);

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.wr_addr   = ld_idx_q[BW +: AW];
  assign bus.wr_data   = bus.in_data;
  assign bus.start     = (state_q == S_START);
  assign bus.rd_en     = rd_issue_s;
  assign bus.rd_bank   = rd_idx_q[BW-1:0];
  assign bus.rd_addr   = rd_idx_q[BW +: AW];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FIN);

  // One-hot bank write strobe for the beat accepted this cycle.
  always_comb begin
    for (int b = 0; b < BN; b++) begin
      bus.wr_en[b] = in_acc_s && (ld_idx_q[BW-1:0] == BW'(b));
    end
  end

  // Next-state and datapath update for the job sequence.
  always_comb begin
    state_d     = state_q;
    ld_idx_d    = ld_idx_q;
    rd_idx_d    = rd_idx_q;
    out_idx_d   = out_idx_q;
    rd_all_d    = rd_all_q;
    inflight_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) state_d = S_LOAD;
        else              state_d = S_IDLE;
      end
      S_LOAD: begin
        if (in_acc_s) begin
          ld_idx_d = ld_idx_q + ONE_IDX;  // wraps to 0 after the last beat
          if (ld_idx_q == LAST_IDX) state_d = S_START;
          else                      state_d = S_LOAD;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (bus.ntt_done) state_d = S_UNLOAD;
        else              state_d = S_RUN;
      end
      S_UNLOAD: begin
        inflight_d = rd_issue_s;
        if (rd_issue_s) begin
          rd_idx_d = rd_idx_q + ONE_IDX;
          if (rd_idx_q == LAST_IDX) rd_all_d = 1'b1;
          else                      rd_all_d = rd_all_q;
        end else begin
          rd_idx_d = rd_idx_q;
        end
        if (inflight_q) begin
          out_data_d  = bus.rd_data;
          out_valid_d = 1'b1;
        end else if (out_acc_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        if (out_acc_s) begin
          out_idx_d = out_idx_q + ONE_IDX;
          if (out_idx_q == LAST_IDX) begin
            state_d  = S_FIN;
            rd_all_d = 1'b0;
          end else begin
            state_d = S_UNLOAD;
          end
        end else begin
          state_d = S_UNLOAD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any job in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_idx_q   <= '0;
      rd_all_q    <= 1'b0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ld_idx_q    <= ld_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_idx_q   <= out_idx_d;
      rd_all_q    <= rd_all_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: doc/ntt_io_ctrl.md
NTT_IO_CTRL -- requirements
Module: ntt_io_ctrl

Interface
REQ-001 SHALL have parameter D_width, default 17, giving the coefficient width (modulus 65537).
REQ-002 SHALL have parameter BN, default 16, giving the number of memory banks.
REQ-003 SHALL have parameter MA, default 64, giving the number of addresses per bank; degree = BN*MA; AW = clog2(MA).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an input coefficient is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the input coefficient.
REQ-008 SHALL have port in_data, input, D_width bits: the input coefficient.
REQ-009 SHALL have port wr_en, output, BN bits: one-hot bank write strobe.
REQ-010 SHALL have port wr_addr, output, AW bits: bank write address.
REQ-011 SHALL have port wr_data, output, D_width bits: bank write data.
REQ-012 SHALL have port start, output, 1 bit: one-cycle pulse that launches the NTT core.
REQ-013 SHALL have port ntt_done, input, 1 bit: the NTT core has finished.
REQ-014 SHALL have port rd_en, output, 1 bit: bank read strobe.
REQ-015 SHALL have port rd_bank, output, clog2(BN) bits: bank to read.
REQ-016 SHALL have port rd_addr, output, AW bits: address to read.
REQ-017 SHALL have port rd_data, input, D_width bits: read data, valid the cycle after rd_en.
REQ-018 SHALL have port out_valid, output, 1 bit: an output coefficient is offered.
REQ-019 SHALL have port out_ready, input, 1 bit: the consumer accepts the output coefficient.
REQ-020 SHALL have port out_data, output, D_width bits: the output coefficient.
REQ-021 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-022 SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.

Function
REQ-023 SHALL implement the states IDLE, LOAD, START, RUN, UNLOAD and FIN.
REQ-024 SHALL go IDLE->LOAD when in_valid=1; no beat is accepted in IDLE (in_ready=0).
REQ-025 SHALL, in LOAD, hold in_ready=1 and treat a beat as accepted when in_valid&&in_ready; beat i (0..degree-1) writes bank i%BN at address i/BN in the same cycle (wr_en one-hot, wr_addr, wr_data=in_data).
REQ-026 SHALL hold wr_en=0 in any cycle with no accepted beat; in_valid gaps stall the load with no write.
REQ-027 SHALL go LOAD->START after accepting beat degree-1; in_ready=0 from the next cycle.
REQ-028 SHALL assert start=1 for exactly one cycle in START, then enter RUN.
REQ-029 SHALL wait in RUN until ntt_done=1, then enter UNLOAD; ntt_done in any other state is ignored.
REQ-030 SHALL, in UNLOAD, read coefficients in index order 0..degree-1 (bank i%BN, address i/BN), with at most one read outstanding.
REQ-031 SHALL issue a read only when no read is in flight and (out_valid=0 or out_ready=1).
REQ-032 SHALL register rd_data into out_data and set out_valid=1 the cycle after the read.
REQ-033 SHALL hold out_data stable while out_valid&&!out_ready.
REQ-034 SHALL clear out_valid after acceptance unless new data is registered in the same cycle.
REQ-035 SHALL sustain a throughput of at least one output beat per 2 cycles when out_ready=1.
REQ-036 SHALL go UNLOAD->FIN when output beat degree-1 is accepted; FIN asserts done=1 for one cycle and returns to IDLE.
REQ-037 SHALL use index counters of exactly clog2(degree) bits that wrap to 0 at job end; no beat is lost or duplicated.

Reset
REQ-038 SHALL, when rst=1 at a clock edge, enter IDLE with all counters 0 and in_ready, wr_en, start, rd_en, out_valid, busy and done all 0; out_data becomes 0.
REQ-039 SHALL apply reset mid-job (any state) identically: the partial load or unload is abandoned with no further writes or reads, and the next job restarts at index 0.
REQ-040 SHALL have rst take priority over every simultaneous input.

Verification
REQ-041 SHALL pass this scenario: stream 1024 beats, data=i, in_valid held high -> bank 5 address 3 written with 53; a single start pulse occurs 1 cycle after beat 1023.
REQ-042 SHALL pass this scenario: ntt_done pulsed while in LOAD, then again in RUN -> only the RUN pulse begins UNLOAD.
REQ-043 SHALL pass this scenario: memory preloaded with value = index, out_ready held 1 -> out_data sequence is 0..1023 in order, followed by exactly one done pulse.
REQ-044 SHALL pass this scenario: out_ready random at 30% duty -> identical ordered sequence, and out_data is stable whenever out_valid is high and out_ready is low.
REQ-045 SHALL pass this scenario: rst asserted after 500 load beats -> all outputs 0 next cycle; a fresh 1024-beat job completes correctly.
REQ-046 SHALL pass this scenario: in_valid toggled every other cycle -> exactly 1024 writes and no write in gap cycles.
